// File: rtl/pla_input_filter.sv
// rtl/pla_input_filter.sv - synchronizing, stability-qualifying input filter ahead of the PLA core
// glitch_cnt port and its counter are built only when PLA_GLITCH_COUNT_EN is defined.
module pla_input_filter #(
  parameter int WIDTH         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             hold,
  output logic [WIDTH-1:0] filt_out,
  output logic             filt_valid,
  output logic             update_pulse
`ifdef PLA_GLITCH_COUNT_EN
  ,
  output logic [7:0]       glitch_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;
  state_t           state_q, state_d;
  logic             acc;
  logic             reject;
  logic             load;

  assign s = sync_q[SYNC_STAGES-1];

  // Candidate restarts on any synchronized change; count saturates once stable.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s != cand_q) begin
      cand_d = s;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q < STABLE_C) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign acc    = (cnt_q == STABLE_C) && (s == cand_q) &&
                  ((cand_q != filt_q) || (state_q == ST_INIT));
  assign reject = (s != cand_q) && (cand_q != filt_q) && (cnt_q < STABLE_C);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (acc && !hold) begin
          load    = 1'b1;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        // hold wins over a simultaneous acceptance
        if (hold) begin
          state_d = ST_FROZEN;
        end else if (acc) begin
          load = 1'b1;
        end
      end
      ST_FROZEN: begin
        if (!hold) begin
          state_d = ST_TRACK;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    filt_d  = load ? cand_q : filt_q;
    valid_d = valid_q | load;
    pulse_d = load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= ONES;
      end
      cand_q  <= ONES;
      cnt_q   <= '0;
      filt_q  <= ONES;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      state_q <= ST_INIT;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
    end
  end

  assign filt_out     = filt_q;
  assign filt_valid   = valid_q;
  assign update_pulse = pulse_q;

`ifdef PLA_GLITCH_COUNT_EN
  logic [7:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    if (reject && (gcnt_q != 8'hFF)) begin
      gcnt_d = gcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_q <= 8'd0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign glitch_cnt = gcnt_q;
`else
  logic unused_reject;
  assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_pla_input_filter.sv
// tb/tb_pla_input_filter.sv - table-driven scoreboard bench for pla_input_filter
module tb_pla_input_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [15:0] raw_in;
  logic [15:0] filt_out;
  logic        filt_valid;
  logic        update_pulse;
`ifdef PLA_GLITCH_COUNT_EN
  logic [7:0]  glitch_cnt;
`endif

  always #5 clk = ~clk;

  pla_input_filter dut (
    .clk          (clk),
    .rst          (rst),
    .raw_in       (raw_in),
    .hold         (hold),
    .filt_out     (filt_out),
    .filt_valid   (filt_valid),
    .update_pulse (update_pulse)
`ifdef PLA_GLITCH_COUNT_EN
    ,
    .glitch_cnt   (glitch_cnt)
`endif
  );

  typedef struct {
    logic        r;
    logic        h;
    logic [15:0] raw;
    int          n;
    logic [15:0] e_filt;
    logic        e_valid;
    logic        e_pulse;
    logic        chk_gc;
    logic [7:0]  e_gc;
  } vec_t;

  typedef struct {
    int          tag;
    logic [15:0] e_filt;
    logic        e_valid;
    logic        e_pulse;
    logic        chk_gc;
    logic [7:0]  e_gc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input logic r, input logic h, input logic [15:0] raw, input int n,
                              input logic [15:0] ef, input logic ev, input logic ep,
                              input logic cg, input logic [7:0] eg);
    vec_t v;
    v.r = r; v.h = h; v.raw = raw; v.n = n;
    v.e_filt = ef; v.e_valid = ev; v.e_pulse = ep; v.chk_gc = cg; v.e_gc = eg;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic h, input logic [15:0] raw,
                      input logic [15:0] ef, input logic ev, input logic ep,
                      input logic cg, input logic [7:0] eg, input int tag);
    exp_t e;
    @(negedge clk);
    rst    = r;
    hold   = h;
    raw_in = raw;
    e.tag = tag; e.e_filt = ef; e.e_valid = ev; e.e_pulse = ep; e.chk_gc = cg; e.e_gc = eg;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (filt_out !== e.e_filt || filt_valid !== e.e_valid || update_pulse !== e.e_pulse) begin
        n_fail++;
        $display("FAIL outputs[row %0d] t=%0t: filt=%h valid=%b pulse=%b, required filt=%h valid=%b pulse=%b",
                 e.tag, $time, filt_out, filt_valid, update_pulse, e.e_filt, e.e_valid, e.e_pulse);
      end
`ifdef PLA_GLITCH_COUNT_EN
      if (e.chk_gc) begin
        n_tests++;
        if (glitch_cnt !== e.e_gc) begin
          n_fail++;
          $display("FAIL glitch_cnt[row %0d] t=%0t: got %0d, required %0d",
                   e.tag, $time, glitch_cnt, e.e_gc);
        end
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    int          waited;
    rst    = 1'b1;
    hold   = 1'b0;
    raw_in = 16'hA5F0;

    // reset release with A5F0 held: load after edge 5
    add(1, 0, 16'hA5F0, 2, 16'hFFFF, 0, 0, 1, 8'd0);
    add(0, 0, 16'hA5F0, 5, 16'hFFFF, 0, 0, 1, 8'd0);
    add(0, 0, 16'hA5F0, 1, 16'hA5F0, 1, 1, 1, 8'd0);
    add(0, 0, 16'hA5F0, 4, 16'hA5F0, 1, 0, 1, 8'd0);
    // single-cycle glitch rejected
    add(0, 0, 16'hA5F1, 1, 16'hA5F0, 1, 0, 1, 8'd0);
    add(0, 0, 16'hA5F0, 2, 16'hA5F0, 1, 0, 1, 8'd0);
    add(0, 0, 16'hA5F0, 6, 16'hA5F0, 1, 0, 1, 8'd1);
    // hold freezes output, release loads on the edge after returning to TRACK
    add(0, 1, 16'h0000, 10, 16'hA5F0, 1, 0, 1, 8'd1);
    add(0, 0, 16'h0000, 1, 16'hA5F0, 1, 0, 1, 8'd1);
    add(0, 0, 16'h0000, 1, 16'h0000, 1, 1, 1, 8'd1);
    add(0, 0, 16'h0000, 3, 16'h0000, 1, 0, 1, 8'd1);
    // skewed bits 3 then 7: only final vector forwarded after edge 6
    add(0, 0, 16'h0008, 1, 16'h0000, 1, 0, 0, 8'd0);
    add(0, 0, 16'h0088, 5, 16'h0000, 1, 0, 0, 8'd0);
    add(0, 0, 16'h0088, 1, 16'h0088, 1, 1, 1, 8'd2);
    add(0, 0, 16'h0088, 3, 16'h0088, 1, 0, 1, 8'd2);
    // reset while cnt==2 toward 1234
    add(0, 0, 16'h1234, 4, 16'h0088, 1, 0, 1, 8'd2);
    add(1, 0, 16'h1234, 1, 16'hFFFF, 0, 0, 1, 8'd0);
    add(0, 0, 16'h1234, 5, 16'hFFFF, 0, 0, 1, 8'd0);
    add(0, 0, 16'h1234, 1, 16'h1234, 1, 1, 1, 8'd0);
    add(0, 0, 16'h1234, 2, 16'h1234, 1, 0, 1, 8'd0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        step(vecs[i].r, vecs[i].h, vecs[i].raw, vecs[i].e_filt, vecs[i].e_valid,
             vecs[i].e_pulse, vecs[i].chk_gc, vecs[i].e_gc, i);
      end
    end

    // 300 back-to-back single-cycle glitches: counter saturates, output untouched
    base = 16'h1234;
    for (int g = 0; g < 300; g++) begin
      step(0, 0, base ^ 16'h0001, base, 1, 0, 0, 8'd0, 1000 + g);
      step(0, 0, base, base, 1, 0, 0, 8'd0, 1000 + g);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, base, base, 1, 0, 1, 8'd255, 2000 + k);
    end

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
